alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, operand/result width matching the team's 4-bit ALU.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 SHALL have ports a0, b0, a1, b1  input  W each  operands of requester 0 / 1.
REQ-006 SHALL have ports op0, op1  input  3 each  ALU opcode of requester 0 / 1.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  one-cycle grant pulse.
REQ-008 SHALL have ports done0, done1  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have port res  output  W  captured ALU result, valid while a done is high.
REQ-010 SHALL have port zero  output  1  captured ALU zero flag, valid while a done is high.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have ports alu_a, alu_b  output  W each, and alu_op  output  3, registered drive to the external ALU.
REQ-013 SHALL have ports alu_result  input  W, and alu_zero  input  1, combinational returns from the external ALU.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on any req, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-015 SHALL, in IDLE with exactly one req high, accept that requester irrespective of priority pointer.
REQ-016 SHALL, in IDLE with both req high, accept the requester selected by a 1-bit round-robin pointer (0 -> requester 0).
REQ-017 SHALL, on acceptance, register the winner's a/b/op into alu_a/alu_b/alu_op and set pointer to the non-winner.
REQ-018 SHALL assert the winner's gnt during EXEC only (exactly one cycle per accepted request).
REQ-019 SHALL, at the end of EXEC, capture alu_result into res and alu_zero into zero.
REQ-020 SHALL assert the winner's done during RESP only, with res/zero valid in that cycle.
REQ-021 SHALL hold res/zero until the next capture; alu_a/alu_b/alu_op stable from EXEC through RESP.
REQ-022 SHALL never assert gnt0 and gnt1, or done0 and done1, in the same cycle.
REQ-023 SHALL ignore req inputs in EXEC and RESP; a req still high on return to IDLE is a new request.
REQ-024 Requesters SHALL hold operands stable until gnt is sampled and drop req by RESP; violation re-issues the op (defined, not an error).
REQ-025 SHALL give latency: req high in IDLE cycle N -> gnt in N+1 -> done in N+2; throughput one op per 3 cycles.
REQ-026 SHALL, with both req held continuously, alternate grants 0,1,0,1,...

Reset
REQ-027 SHALL, while rst_n is low at a clock edge, force state IDLE, pointer 0, gnt0/1=0, done0/1=0, busy=0, res=0, zero=0, alu_a=0, alu_b=0, alu_op=0.
REQ-028 SHALL, on reset during EXEC or RESP, abort the operation with no done pulse emitted.
REQ-029 SHALL accept a request in the first clock edge after rst_n is sampled high.

Verification (team 4-bit ALU attached: op 000 add, 001 subtract)
REQ-030 Bench SHALL check: req0 only, a0=3,b0=4,op0=000 -> gnt0 one cycle later, done0 two cycles later with res=7, zero=0.
REQ-031 Bench SHALL check: req1 only, a1=5,b1=5,op1=001 -> done1 with res=0, zero=1; gnt0/done0 never high.
REQ-032 Bench SHALL check: req0 and req1 together after reset (a0=5,b0=2,op0=001; a1=9,b1=9,op1=001) -> requester 0 served first (res=3, zero=0), then requester 1 (res=0, zero=1).
REQ-033 Bench SHALL check: both req held high for 12 cycles -> grant order 0,1,0,1, each gnt-to-gnt spacing 3 cycles, busy low exactly one cycle between ops.
REQ-034 Bench SHALL check: rst_n driven low during EXEC of a request -> no done pulse, all outputs 0 next cycle, pending req accepted on first edge after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// Round-robin arbitration, registered ALU drive, captured result/zero flag.
module alu_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [2:0]   op0,
  input  logic [2:0]   op1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res,
  output logic         zero,
  output logic         busy,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         winner_q, winner_d;
  logic         gnt0_q, gnt0_d;
  logic         gnt1_q, gnt1_d;
  logic         done0_q, done0_d;
  logic         done1_q, done1_d;
  logic         busy_q, busy_d;
  logic [W-1:0] res_q, res_d;
  logic         zero_q, zero_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic         pick;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    busy_d   = busy_q;
    res_d    = res_q;
    zero_d   = zero_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    // A lone requester wins outright; the pointer only breaks ties.
    pick     = (req0 && req1) ? ptr_q : req1;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (req0 || req1) begin
          state_d  = StExec;
          winner_d = pick;
          ptr_d    = ~pick;
          busy_d   = 1'b1;
          gnt0_d   = ~pick;
          gnt1_d   = pick;
          alu_a_d  = pick ? a1 : a0;
          alu_b_d  = pick ? b1 : b0;
          alu_op_d = pick ? op1 : op0;
        end
      end
      StExec: begin
        state_d = StResp;
        busy_d  = 1'b1;
        res_d   = alu_result;
        zero_d  = alu_zero;
        done0_d = ~winner_q;
        done1_d = winner_q;
      end
      StResp: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      winner_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = busy_q;
  assign res    = res_q;
  assign zero   = zero_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural 4-bit ALU and a result scoreboard.
module tb_alu_arbiter;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   op0, op1;
  logic         gnt0, gnt1, done0, done1, zero, busy;
  logic [W-1:0] res, alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         alu_zero;

  typedef struct {
    int           who;
    logic [W-1:0] res;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   gnt_times[$];
  int   gnt_who[$];

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .op0        (op0),
    .op1        (op1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .res        (res),
    .zero       (zero),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  // External team ALU: 000 add, 001 subtract, 010 and, 011 or, others xor.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int who, input logic [W-1:0] r, input logic z);
    exp_t e;
    e.who  = who;
    e.res  = r;
    e.zero = z;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {gnt0, gnt1, done0, done1, busy, zero}, 32'd0);
    check_eq({tag, "_res"}, res, 32'd0);
    check_eq({tag, "_alu"}, {alu_a, alu_b, alu_op}, 32'd0);
  endtask

  // Scoreboard: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check_eq("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      if (done0 || done1) begin
        check_eq("done_excl", {31'd0, done0 & done1}, 32'd0);
        if (sb.size() == 0) begin
          check_eq("spurious_done", {30'd0, done1, done0}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("sb_who", done1 ? 32'd1 : 32'd0, e.who);
          check_eq("sb_res", res, e.res);
          check_eq("sb_zero", zero, e.zero);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {req0, req1} = 2'b00;
    {a0, b0, a1, b1} = '0;
    {op0, op1} = '0;
    tick();
    tick();
    check_all_zero("reset");

    // Single request from 0: add 3+4, request raised on the release edge.
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd4; op0 = 3'b000;
    push_exp(0, 4'd7, 1'b0);
    tick();
    check_eq("t1_gnt", {gnt0, gnt1, done0, done1, busy}, 32'b10001);
    check_eq("t1_alu", {alu_a, alu_b, alu_op}, {21'd0, 4'd3, 4'd4, 3'b000});
    req0 = 1'b0;
    tick();
    check_eq("t1_done", {gnt0, gnt1, done0, done1, busy}, 32'b00101);
    check_eq("t1_res", {res, zero}, {4'd7, 1'b0});
    tick();
    check_eq("t1_idle", {gnt0, gnt1, done0, done1, busy}, 32'd0);

    // Single request from 1: 5-5 gives zero.
    req1 = 1'b1; a1 = 4'd5; b1 = 4'd5; op1 = 3'b001;
    push_exp(1, 4'd0, 1'b1);
    tick();
    check_eq("t2_gnt", {gnt0, gnt1, done0, done1}, 32'b0100);
    req1 = 1'b0;
    tick();
    check_eq("t2_done", {gnt0, gnt1, done0, done1}, 32'b0001);
    check_eq("t2_res", {res, zero}, {4'd0, 1'b1});
    tick();

    // Simultaneous requests after reset: 0 first, then 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd2; op0 = 3'b001;
    req1 = 1'b1; a1 = 4'd9; b1 = 4'd9; op1 = 3'b001;
    push_exp(0, 4'd3, 1'b0);
    push_exp(1, 4'd0, 1'b1);
    tick();
    check_eq("t3_gnt0", {gnt0, gnt1}, 32'b10);
    tick();
    check_eq("t3_done0", {done0, done1, res, zero}, {2'b10, 4'd3, 1'b0});
    req0 = 1'b0;
    tick();
    check_eq("t3_idle", busy, 32'd0);
    tick();
    check_eq("t3_gnt1", {gnt0, gnt1}, 32'b01);
    req1 = 1'b0;
    tick();
    check_eq("t3_done1", {done0, done1, res, zero}, {2'b01, 4'd0, 1'b1});
    tick();

    // Both requests held: alternating grants every third cycle.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd2; op0 = 3'b000;
    req1 = 1'b1; a1 = 4'd7; b1 = 4'd3; op1 = 3'b001;
    push_exp(0, 4'd3, 1'b0);
    push_exp(1, 4'd4, 1'b0);
    push_exp(0, 4'd3, 1'b0);
    push_exp(1, 4'd4, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 11) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (gnt0 || gnt1) begin
        gnt_times.push_back(k);
        gnt_who.push_back(gnt1 ? 1 : 0);
      end
      check_eq($sformatf("t4_busy_%0d", k), busy, (k % 3 != 0) ? 32'd1 : 32'd0);
    end
    check_eq("t4_ngnt", gnt_times.size(), 32'd4);
    for (int i = 0; i < gnt_who.size(); i++) begin
      check_eq($sformatf("t4_order_%0d", i), gnt_who[i], (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        check_eq($sformatf("t4_space_%0d", i), gnt_times[i] - gnt_times[i-1], 32'd3);
      end
    end
    tick();

    // Reset during EXEC aborts; held request is taken on the first edge after release.
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd3; op0 = 3'b000;
    tick();
    check_eq("t5_gnt", {gnt0, busy}, 32'b11);
    rst_n = 1'b0;
    tick();
    check_all_zero("t5_abort");
    rst_n = 1'b1;
    push_exp(0, 4'd5, 1'b0);
    tick();
    check_eq("t5_regnt", {gnt0, gnt1, busy}, 32'b101);
    req0 = 1'b0;
    tick();
    check_eq("t5_done", {done0, res}, {1'b1, 4'd5});
    tick();
    tick();

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
